// File: rtl/wordcopy_pkg.sv
// wordcopy_pkg: register offsets and FSM state encodings shared by the word copy accelerator.
package wordcopy_pkg;
    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_SRC  = 4'd1;
    localparam logic [3:0] REG_DST  = 4'd2;
    localparam logic [3:0] REG_CNT  = 4'd3;
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ACK, S_RELEASE} slv_state_t;
    typedef enum logic [1:0] {E_IDLE, E_RD_REQ, E_RD_WAIT, E_WR_REQ} eng_state_t;
endpackage

// File: rtl/wordcopy_engine.sv
// wordcopy_engine: Avalon-MM master that copies cnt words from src to dst, one read then one write per word.
module wordcopy_engine
    import wordcopy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] src_i,
    input  logic [31:0] dst_i,
    input  logic [31:0] cnt_i,
    output logic        busy_o,
    input  logic        master_waitrequest_i,
    output logic [31:0] master_address_o,
    output logic        master_read_o,
    input  logic [31:0] master_readdata_i,
    input  logic        master_readdatavalid_i,
    output logic        master_write_o,
    output logic [31:0] master_writedata_o
);
    eng_state_t  state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, idx_q, idx_d, data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= E_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            E_IDLE: if (start_i) begin
                src_d   = src_i;
                dst_d   = dst_i;
                cnt_d   = cnt_i;
                idx_d   = '0;
                state_d = (cnt_i == '0) ? E_IDLE : E_RD_REQ;
            end
            E_RD_REQ: state_d = master_waitrequest_i ? E_RD_REQ : E_RD_WAIT;
            E_RD_WAIT: if (master_readdatavalid_i) begin
                data_d  = master_readdata_i;
                state_d = E_WR_REQ;
            end
            E_WR_REQ: if (!master_waitrequest_i) begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q + 32'd1 == cnt_q) ? E_IDLE : E_RD_REQ;
            end
        endcase
    end

    // Addresses are combinational from the registered state, so they stay put while stalled.
    assign busy_o             = state_q != E_IDLE;
    assign master_read_o      = state_q == E_RD_REQ;
    assign master_write_o     = state_q == E_WR_REQ;
    assign master_address_o   = master_read_o  ? src_q + {idx_q[29:0], 2'b00} :
                                master_write_o ? dst_q + {idx_q[29:0], 2'b00} : '0;
    assign master_writedata_o = data_q;
endmodule

// File: rtl/wordcopy.sv
// wordcopy: memory-to-memory word copy accelerator; Avalon-MM slave register file and handshake FSM
// driving the copy engine. An offset-0 read stalls until the engine is idle.
module wordcopy
    import wordcopy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    slv_state_t  state_q, state_d;
    logic        wr_q, wr_d, req, wr_req, busy, start;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, rdata_q, rdata_d;

    // Only a definite 1 counts as a request; X or 0 is ignored.
    assign wr_req = slave_write === 1'b1;
    assign req    = wr_req || (slave_read === 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (req) begin
                state_d = S_HOLD;
                wr_d    = wr_req;
                addr_d  = slave_address;
            end
            S_HOLD: state_d = (addr_q == REG_CTRL && busy) ? S_HOLD : S_ACK;
            S_ACK: begin
                state_d = S_RELEASE;
                src_d   = (wr_q && addr_q == REG_SRC) ? slave_writedata : src_q;
                dst_d   = (wr_q && addr_q == REG_DST) ? slave_writedata : dst_q;
                cnt_d   = (wr_q && addr_q == REG_CNT) ? slave_writedata : cnt_q;
                rdata_d = wr_q                ? rdata_q :
                          addr_q == REG_SRC   ? src_q   :
                          addr_q == REG_DST   ? dst_q   :
                          addr_q == REG_CNT   ? cnt_q   : '0;
            end
            S_RELEASE: state_d = req ? S_RELEASE : S_IDLE;
        endcase
    end

    assign slave_waitrequest = req && state_q != S_ACK && state_q != S_RELEASE;
    assign slave_readdata    = rdata_q;
    assign start             = state_q == S_ACK && wr_q && addr_q == REG_CTRL;

    wordcopy_engine u_engine (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start_i                (start),
        .src_i                  (src_q),
        .dst_i                  (dst_q),
        .cnt_i                  (cnt_q),
        .busy_o                 (busy),
        .master_waitrequest_i   (master_waitrequest),
        .master_address_o       (master_address),
        .master_read_o          (master_read),
        .master_readdata_i      (master_readdata),
        .master_readdatavalid_i (master_readdatavalid),
        .master_write_o         (master_write),
        .master_writedata_o     (master_writedata)
    );
endmodule

// File: tb/tb_wordcopy.sv
// tb_wordcopy: directed vector table for the register file plus hand-written copy, stall, zero-count
// and mid-copy reset sequences, with a bus monitor checking every master transfer.
module tb_wordcopy;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    wordcopy dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int rd_n = 0, wr_n = 0, rd_stalls = 0, wr_stalls = 0, last_wr_cyc = 0;
    logic [31:0] exp_src = '0, exp_dst = '0, exp_data = '0, last_wr_addr = '0;
    logic        stall_rd = 1'b0, stall_wr = 1'b0;
    logic [31:0] stall_addr = '0, stall_data = '0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Bus monitor: samples at negedge, a transfer is accepted when its request is high and waitrequest low.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_rd = 1'b0;
            stall_wr = 1'b0;
        end else begin
            chk(!(master_read && master_write), "rw_exclusive", {30'd0, master_read, master_write}, 32'd0);
            if (stall_rd) chk(master_read && master_address == stall_addr, "rd_hold", master_address, stall_addr);
            if (stall_wr) chk(master_write && master_address == stall_addr && master_writedata == stall_data,
                              "wr_hold", master_writedata, stall_data);
            stall_rd = master_read && master_waitrequest;
            stall_wr = master_write && master_waitrequest;
            stall_addr = master_address;
            stall_data = master_writedata;
            if (stall_rd) rd_stalls++;
            if (stall_wr) wr_stalls++;
            if (master_read && !master_waitrequest) begin
                chk(master_address == exp_src + 32'(4 * rd_n), "rd_addr", master_address, exp_src + 32'(4 * rd_n));
                rd_n++;
            end
            if (master_write && !master_waitrequest) begin
                chk(master_address == exp_dst + 32'(4 * wr_n), "wr_addr", master_address, exp_dst + 32'(4 * wr_n));
                chk(master_writedata == exp_data, "wr_data", master_writedata, exp_data);
                wr_n++;
                last_wr_addr = master_address;
                last_wr_cyc = cyc;
            end
        end
    end

    task automatic slv_access(input bit wr, input logic [3:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output int waits, output int done_cyc);
        @(posedge clk); #1;
        slave_address = a;
        slave_writedata = wd;
        slave_write = wr;
        slave_read = !wr;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!slave_waitrequest) break;
            waits++;
            if (waits > 5000) begin
                chk(1'b0, "slave_timeout", 32'(waits), 32'd5000);
                break;
            end
        end
        done_cyc = cyc;
        @(posedge clk); #1;
        slave_write = 1'b0;
        slave_read = 1'b0;
        @(negedge clk);
        rd = slave_readdata;
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t        v[5];
    logic [31:0] r;
    int          w, dc;

    initial begin
        v[0] = '{4'd1,  32'hAAAA1110, 32'hAAAA1110};
        v[1] = '{4'd2,  32'hBBBB2220, 32'hBBBB2220};
        v[2] = '{4'd3,  32'h00000100, 32'h00000100};
        v[3] = '{4'd4,  32'hDEADBEEF, 32'h00000000};
        v[4] = '{4'd15, 32'h12345678, 32'h00000000};

        repeat (3) @(posedge clk);
        #1 chk({master_read, master_write, slave_waitrequest} == 3'b000 && master_address == '0 &&
               master_writedata == '0 && slave_readdata == '0, "reset_outputs", master_address, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            slv_access(1'b1, v[i].a, v[i].wd, r, w, dc);
            chk(w == 2, "wr_wait_cycles", 32'(w), 32'd2);
        end
        for (int i = 0; i < 5; i++) begin
            slv_access(1'b0, v[i].a, 32'h0, r, w, dc);
            chk(r == v[i].rd, "reg_readback", r, v[i].rd);
        end

        // Full 256-word copy with a blocking done-read issued mid-copy.
        master_readdata = 32'hFEFEFEFE;
        master_readdatavalid = 1'b1;
        exp_src = 32'hAAAA1110;
        exp_dst = 32'hBBBB2220;
        exp_data = 32'hFEFEFEFE;
        rd_n = 0;
        wr_n = 0;
        slv_access(1'b1, 4'd0, 32'hFFFFFFFF, r, w, dc);
        repeat (10) @(posedge clk);
        slv_access(1'b0, 4'd0, 32'h0, r, w, dc);
        chk(r == 32'd0, "done_readdata", r, 32'd0);
        chk(rd_n == 256, "copy_reads", 32'(rd_n), 32'd256);
        chk(wr_n == 256, "copy_writes", 32'(wr_n), 32'd256);
        chk(last_wr_addr == 32'hBBBB261C, "last_wr_addr", last_wr_addr, 32'hBBBB261C);
        chk(dc == last_wr_cyc + 2, "done_release_cycle", 32'(dc), 32'(last_wr_cyc + 2));

        // Stalled read and write with a source address that wraps past 0xFFFFFFFC.
        master_readdata = 32'h13579BDF;
        exp_src = 32'hFFFFFFFC;
        exp_dst = 32'h00000200;
        exp_data = 32'h13579BDF;
        slv_access(1'b1, 4'd1, exp_src, r, w, dc);
        slv_access(1'b1, 4'd2, exp_dst, r, w, dc);
        slv_access(1'b1, 4'd3, 32'd2, r, w, dc);
        rd_n = 0;
        wr_n = 0;
        rd_stalls = 0;
        wr_stalls = 0;
        master_waitrequest = 1'b1;
        slv_access(1'b1, 4'd0, 32'h0, r, w, dc);
        for (int k = 0; k < 100 && !master_read; k++) @(negedge clk);
        chk(master_read, "stall_rd_seen", {31'd0, master_read}, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 master_waitrequest = 1'b0;
        @(posedge clk); #1 master_waitrequest = 1'b1;
        for (int k = 0; k < 100 && !master_write; k++) @(negedge clk);
        chk(master_write, "stall_wr_seen", {31'd0, master_write}, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 master_waitrequest = 1'b0;
        slv_access(1'b0, 4'd0, 32'h0, r, w, dc);
        chk(rd_n == 2, "stall_reads", 32'(rd_n), 32'd2);
        chk(wr_n == 2, "stall_writes", 32'(wr_n), 32'd2);
        chk(rd_stalls >= 3, "rd_stall_cycles", 32'(rd_stalls), 32'd3);
        chk(wr_stalls >= 3, "wr_stall_cycles", 32'(wr_stalls), 32'd3);
        chk(last_wr_addr == 32'h00000204, "stall_last_addr", last_wr_addr, 32'h00000204);

        // Zero count: no master traffic and the done-read is not blocked.
        slv_access(1'b1, 4'd3, 32'd0, r, w, dc);
        rd_n = 0;
        wr_n = 0;
        slv_access(1'b1, 4'd0, 32'h0, r, w, dc);
        slv_access(1'b0, 4'd0, 32'h0, r, w, dc);
        chk(w == 2, "zero_cnt_wait", 32'(w), 32'd2);
        chk(rd_n + wr_n == 0, "zero_cnt_traffic", 32'(rd_n + wr_n), 32'd0);

        // Asynchronous reset in the middle of a copy.
        exp_src = 32'h00001000;
        exp_dst = 32'h00002000;
        slv_access(1'b1, 4'd1, exp_src, r, w, dc);
        slv_access(1'b1, 4'd2, exp_dst, r, w, dc);
        slv_access(1'b1, 4'd3, 32'h100, r, w, dc);
        rd_n = 0;
        wr_n = 0;
        slv_access(1'b1, 4'd0, 32'h0, r, w, dc);
        for (int k = 0; k < 200 && wr_n < 5; k++) @(posedge clk);
        chk(wr_n >= 5, "copy_running", 32'(wr_n), 32'd5);
        for (int k = 0; k < 10 && !master_read; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk({master_read, master_write} == 2'b00 && master_address == '0 && master_writedata == '0,
               "async_reset_drop", master_address, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 4; i++) begin
            slv_access(1'b0, 4'(i), 32'h0, r, w, dc);
            chk(r == 32'd0, "reg_after_reset", r, 32'd0);
        end
        repeat (5) @(negedge clk);
        chk({master_read, master_write} == 2'b00, "idle_after_reset", {30'd0, master_read, master_write}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wordcopy.md
Name: wordcopy

Overview:
Memory-to-memory word copy accelerator. The CPU programs source, destination and word count through an Avalon-MM slave. A write to offset 0 starts the copy. An Avalon-MM master then reads each 32-bit word from SDRAM and writes it to the destination. A read of offset 0 stalls until the copy completes, which gives the CPU a blocking "wait for done".

Parameters:
none (data/address widths fixed at 32, slave address 4 bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
slave_waitrequest  out  1  stall for the current slave read/write
slave_address  in  4  word offset of register
slave_read  in  1  slave read request
slave_readdata  out  32  slave read data
slave_write  in  1  slave write request
slave_writedata  in  32  slave write data
master_waitrequest  in  1  SDRAM stall
master_address  out  32  byte address
master_read  out  1  master read request
master_readdata  in  32  master read data
master_readdatavalid  in  1  read data valid
master_write  out  1  master write request
master_writedata  out  32  master write data

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all registers 0, slave FSM IDLE, engine IDLE. Outputs: slave_readdata=0, master_read=0, master_write=0, master_address=0, master_writedata=0.
- Register map:
  - 1 = src byte address (R/W)
  - 2 = dst byte address (R/W)
  - 3 = word count (R/W)
  - 0 write = start, writedata ignored
  - 0 read = blocks until idle, returns 0
  - 4..15: writes ignored, reads return 0
- Request qualification: a request exists only when slave_read===1 or slave_write===1. X/0 inputs are treated as no request.
- Slave FSM states IDLE -> HOLD -> ACK -> RELEASE -> IDLE.
  - IDLE: on request, go to HOLD. If read and write are both high, write wins.
  - HOLD: lasts at least 1 cycle. Go to ACK only if the access may complete:
    - offset-0 read or write while engine busy stays in HOLD;
    - otherwise complete next cycle.
  - ACK (1 cycle): the write updates its register, or slave_readdata is registered. An offset-0 write pulses start to the engine.
  - RELEASE: wait until read and write are both low, then IDLE. This prevents a held request from being accepted twice.
- slave_waitrequest = request present and state != ACK and state != RELEASE. It is therefore high for at least 2 cycles after a request appears.
- slave_readdata holds its value until the next completed read.
- Engine: on start, latch src, dst, count; clear index i.
  - Count = 0: return to IDLE immediately.
  - Otherwise: RD_REQ -> RD_WAIT -> WR_REQ -> (next word or IDLE).
- RD_REQ: master_read=1, master_address = src_l + 4*i. Hold until master_waitrequest=0 (accept edge).
- RD_WAIT: master_read=0. On master_readdatavalid=1, capture master_readdata. Valid is sampled only in this state, never in the accept cycle.
- WR_REQ: master_write=1, master_address = dst_l + 4*i, master_writedata = captured word. Hold until master_waitrequest=0. Then i++.
  - If i == count, go to IDLE (done).
  - Else go to RD_REQ.
- master_read and master_write are never high together. Address and data stay stable while waitrequest is high.
- Address arithmetic is 32-bit modulo (wraps); no alignment check.
- Register writes to 1..3 during a copy update the registers only; the running copy uses its latched values.
- Async reset mid-copy aborts the copy immediately; outputs return to reset values.

Decomposition:
- Package wordcopy_pkg: register offset constants (REG_CTRL=0, REG_SRC=1, REG_DST=2, REG_CNT=3), slave FSM enum, engine FSM enum.
- One sub-module, wordcopy_engine: the master-side copy FSM with start/busy handshake. The top holds the slave register file and slave FSM.

Test Plan:
- Reset, then write src=0xAAAA1110, dst=0xBBBB2220, count=0x100. Each write -> slave_waitrequest=1 one cycle after request, then falls; registers updated once.
- Read back offsets 1/2/3 -> 0xAAAA1110, 0xBBBB2220, 0x00000100, valid the cycle after waitrequest falls.
- Write offset 0 with master_readdata=0xFEFEFEFE, readdatavalid=1, master_waitrequest=0:
  - 256 reads at 0xAAAA1110+4i, then 256 interleaved writes of 0xFEFEFEFE to 0xBBBB2220+4i;
  - last write address 0xBBBB261C;
  - no concurrent read/write.
- Read offset 0 ten cycles after start -> waitrequest held until the 256th write is accepted, then released; readdata=0.
- Pulse master_waitrequest=1 for 3 cycles during RD_REQ and WR_REQ -> address/data held, no duplicate transfer; count=0 start -> no master activity, offset-0 read completes in 2 cycles.
- Assert rst_n=0 mid-copy -> master_read/master_write drop immediately; all registers read 0 after release.
